// File: rtl/ddr2_wr_arb_pkg.sv
// ddr2_arb_pkg: shared definitions for the DDR2 write-port arbiter.
//   - arb_state_e   : arbiter FSM state encoding (IDLE / ISSUE / DATA)
//   - LEN_WIDTH_DEF : default width of the transfer length field in words
package ddr2_arb_pkg;

    localparam int LEN_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ddr2_wr_arb_if.sv
// ddr2_wr_arb_if: user-side write port of axi_wr_master.
//   m_wr_trig / m_wr_len / m_wr_addr : burst request (arbiter -> master)
//   m_wr_data                        : current write word (arbiter -> master)
//   m_wr_data_en                     : beat strobe (master -> arbiter)
//   m_wr_ready                       : request accepted (master -> arbiter)
//   m_wr_done                        : burst finished (master -> arbiter)
// Modport master is the arbiter side; modport slave is the axi_wr_master side.
interface ddr2_wr_arb_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
);
    logic                  m_wr_trig;
    logic [LEN_WIDTH-1:0]  m_wr_len;
    logic [ADDR_WIDTH-1:0] m_wr_addr;
    logic [DATA_WIDTH-1:0] m_wr_data;
    logic                  m_wr_data_en;
    logic                  m_wr_ready;
    logic                  m_wr_done;

    modport master (
        output m_wr_trig, m_wr_len, m_wr_addr, m_wr_data,
        input  m_wr_data_en, m_wr_ready, m_wr_done
    );

    modport slave (
        input  m_wr_trig, m_wr_len, m_wr_addr, m_wr_data,
        output m_wr_data_en, m_wr_ready, m_wr_done
    );
endinterface

// File: rtl/ddr2_wr_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i   : request vector
//   ptr_i   : highest-priority index this round
//   grant_o : one-hot winner (zero when no request)
//   idx_o   : winner index
//   valid_o : at least one request present
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    // Scan from the farthest candidate back to ptr_i so the nearest request wins by overwrite.
    always_comb begin
        int cand;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr_i) + k;
            cand = (cand >= N_REQ) ? (cand - N_REQ) : cand;
            if (|(req_i & (ONE << cand))) begin
                grant_o = ONE << cand;
                idx_o   = IDX_W'(cand);
                valid_o = 1'b1;
            end else begin
                valid_o = valid_o;
            end
        end
    end
endmodule

// File: rtl/ddr2_wr_arb.sv
// ddr2_wr_arb: round-robin scheduler sharing the axi_wr_master write port
// between N_REQ clients.
//   clk, rst          : clock, synchronous active-high reset
//   init_end_i        : DDR2 init done; gates new grants only
//   req_trig_i        : per-client request (held until req_ready_o)
//   req_len_i/addr_i  : per-client length (words) / start address slices
//   req_data_i        : per-client current write word slices
//   req_data_en_o     : beat strobe routed to the owner (combinational)
//   req_ready_o       : one-cycle accept pulse to the owner
//   req_done_o        : one-cycle completion pulse to the owner
//   req_grant_o       : one-hot owner, zero when idle
//   len_err_o         : one-cycle pulse when beats at done != latched length
//   m_if              : axi_wr_master user port (master modport)
module ddr2_wr_arb
    import ddr2_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         init_end_i,
    input  logic [N_REQ-1:0]             req_trig_i,
    input  logic [N_REQ*LEN_WIDTH-1:0]   req_len_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]  req_data_i,
    output logic [N_REQ-1:0]             req_data_en_o,
    output logic [N_REQ-1:0]             req_ready_o,
    output logic [N_REQ-1:0]             req_done_o,
    output logic [N_REQ-1:0]             req_grant_o,
    output logic                         len_err_o,
    ddr2_wr_arb_if.master                m_if
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // One extra bit so an overrun of a maximum-length burst is still detected.
    localparam int CNT_W = LEN_WIDTH + 1;

    arb_state_e              state_q;
    logic [IDX_W-1:0]        ptr_q;
    logic [IDX_W-1:0]        owner_q;
    logic [N_REQ-1:0]        grant_q;
    logic [N_REQ-1:0]        ready_q;
    logic [N_REQ-1:0]        done_q;
    logic                    len_err_q;
    logic                    trig_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;

    logic [N_REQ-1:0]        arb_grant_s;
    logic [IDX_W-1:0]        arb_idx_s;
    logic                    arb_valid_s;
    logic [LEN_WIDTH-1:0]    win_len_s;
    logic [ADDR_WIDTH-1:0]   win_addr_s;
    logic [DATA_WIDTH-1:0]   data_mux_s;
    logic [IDX_W-1:0]        ptr_own_s;
    logic [IDX_W-1:0]        ptr_win_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i   (req_trig_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant_s),
        .idx_o   (arb_idx_s),
        .valid_o (arb_valid_s)
    );

    // Select the winner's request fields and the owner's data word.
    always_comb begin
        win_len_s  = '0;
        win_addr_s = '0;
        data_mux_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_len_s  = (arb_idx_s == IDX_W'(i)) ? req_len_i[i*LEN_WIDTH +: LEN_WIDTH]    : win_len_s;
            win_addr_s = (arb_idx_s == IDX_W'(i)) ? req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] : win_addr_s;
            data_mux_s = (owner_q == IDX_W'(i))   ? req_data_i[i*DATA_WIDTH +: DATA_WIDTH] : data_mux_s;
        end
    end

    // Pointer successors (modulo N_REQ) and saturating beat count including this cycle's strobe.
    always_comb begin
        ptr_own_s = (owner_q == IDX_W'(N_REQ - 1))   ? '0 : owner_q + 1'b1;
        ptr_win_s = (arb_idx_s == IDX_W'(N_REQ - 1)) ? '0 : arb_idx_s + 1'b1;
        cnt_d     = (m_if.m_wr_data_en && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    // Arbiter FSM with all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            ready_q   <= '0;
            done_q    <= '0;
            len_err_q <= 1'b0;
            trig_q    <= 1'b0;
            len_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            ready_q   <= '0;
            done_q    <= '0;
            len_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_q != '0) begin
                        // Grant cycle of a zero-length request: release, no arbitration this cycle.
                        grant_q <= '0;
                    end else if (init_end_i && arb_valid_s) begin
                        grant_q <= arb_grant_s;
                        owner_q <= arb_idx_s;
                        len_q   <= win_len_s;
                        addr_q  <= win_addr_s;
                        cnt_q   <= '0;
                        if (win_len_s == '0) begin
                            // Nothing to move: acknowledge and complete without the master.
                            ready_q <= arb_grant_s;
                            done_q  <= arb_grant_s;
                            ptr_q   <= ptr_win_s;
                        end else begin
                            trig_q  <= 1'b1;
                            state_q <= ST_ISSUE;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE, ST_DATA: begin
                    cnt_q <= cnt_d;
                    if (m_if.m_wr_done) begin
                        done_q    <= grant_q;
                        len_err_q <= (cnt_d != {1'b0, len_q});
                        ptr_q     <= ptr_own_s;
                        grant_q   <= '0;
                        trig_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if ((state_q == ST_ISSUE) && m_if.m_wr_ready) begin
                        trig_q  <= 1'b0;
                        ready_q <= grant_q;
                        state_q <= ST_DATA;
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_grant_o   = grant_q;
    assign req_ready_o   = ready_q;
    assign req_done_o    = done_q;
    assign len_err_o     = len_err_q;
    assign req_data_en_o = ((state_q == ST_DATA) && m_if.m_wr_data_en) ? grant_q : '0;

    assign m_if.m_wr_trig = trig_q;
    assign m_if.m_wr_len  = len_q;
    assign m_if.m_wr_addr = addr_q;
    assign m_if.m_wr_data = data_mux_s;
endmodule

// File: tb/tb_ddr2_wr_arb.sv
// tb_ddr2_wr_arb: directed scenarios for ddr2_wr_arb with a per-cycle
// transaction-level reference model, client models and an axi_wr_master model.
module tb_ddr2_wr_arb;
    localparam int N  = 2;
    localparam int AW = 27;
    localparam int DW = 16;
    localparam int LW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            init_end;
    logic [N-1:0]    req_trig;
    logic [N*LW-1:0] req_len;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_data_en, req_ready, req_done, req_grant;
    logic            len_err;

    ddr2_wr_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) m_if ();

    ddr2_wr_arb #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .init_end_i(init_end),
        .req_trig_i(req_trig), .req_len_i(req_len), .req_addr_i(req_addr), .req_data_i(req_data),
        .req_data_en_o(req_data_en), .req_ready_o(req_ready), .req_done_o(req_done),
        .req_grant_o(req_grant), .len_err_o(len_err), .m_if(m_if)
    );

    int n_checks = 0, n_errors = 0, cyc = 0;
    // stimulus controls
    bit rst_cmd = 1'b1, init_cmd = 1'b0;
    int pend[N], cl_len[N], cl_addr[N], beat[N];
    bit seen_rdy[N], seen_den[N];
    // master model
    int ms = 0, wc = 0, bl = 0, rdy_dly = 3, beats_cfg = -1;
    bit gap_cfg = 1'b0, stray_req = 1'b0;
    // reference model
    int mo_owner = -1, mo_len = 0, mo_addr = 0, mo_beats = 0, mo_ptr = 0;
    bit mo_acked = 1'b0, mo_zl = 1'b0, mo_trig = 1'b0;
    bit p_rst = 1'b1, p_init = 1'b0, p_den = 1'b0, p_rdy = 1'b0, p_done = 1'b0;
    logic [N-1:0] p_trig = '0;
    int p_len[N], p_addr[N];
    // statistics
    int n_rdy[N], n_done[N], n_den[N];
    int n_err_pulse, err_cyc, mdone_cyc, first_trig, zl_both;
    int order[$];
    logic [N-1:0] prev_grant = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Reference model step (inputs of the previous cycle) plus per-cycle compare.
    task automatic compare();
        int w;
        logic [N-1:0] e_rdy, e_done, e_grant, e_den;
        bit e_err;
        e_rdy = '0; e_done = '0; e_err = 1'b0;
        if (p_rst) begin
            mo_owner = -1; mo_ptr = 0; mo_len = 0; mo_addr = 0; mo_beats = 0;
            mo_trig = 1'b0; mo_acked = 1'b0; mo_zl = 1'b0;
        end else if (mo_zl) begin
            mo_zl = 1'b0; mo_owner = -1;
        end else if (mo_owner < 0) begin
            w = rr_pick(p_trig, mo_ptr);
            if (p_init && w >= 0) begin
                mo_owner = w; mo_len = p_len[w]; mo_addr = p_addr[w];
                mo_beats = 0; mo_acked = 1'b0;
                if (mo_len == 0) begin
                    e_rdy = N'(1) << w; e_done = N'(1) << w;
                    mo_ptr = (w + 1) % N; mo_zl = 1'b1;
                end else begin
                    mo_trig = 1'b1;
                end
            end
        end else begin
            if (p_den && mo_beats < 511) mo_beats++;
            if (p_done) begin
                e_done = N'(1) << mo_owner;
                e_err = (mo_beats != mo_len);
                mo_ptr = (mo_owner + 1) % N;
                mo_owner = -1; mo_trig = 1'b0;
            end else if (!mo_acked && p_rdy) begin
                e_rdy = N'(1) << mo_owner;
                mo_acked = 1'b1; mo_trig = 1'b0;
            end
        end
        e_grant = (mo_owner >= 0) ? (N'(1) << mo_owner) : '0;
        e_den = (mo_owner >= 0 && mo_acked && !mo_zl && m_if.m_wr_data_en) ? e_grant : '0;

        chk("grant", 64'(req_grant), 64'(e_grant));
        chk("grant_onehot0", 64'($onehot0(req_grant)), 64'(1));
        chk("ready", 64'(req_ready), 64'(e_rdy));
        chk("done", 64'(req_done), 64'(e_done));
        chk("len_err", 64'(len_err), 64'(e_err));
        chk("m_wr_trig", 64'(m_if.m_wr_trig), 64'(mo_trig));
        chk("m_wr_len", 64'(m_if.m_wr_len), 64'(mo_len));
        chk("m_wr_addr", 64'(m_if.m_wr_addr), 64'(mo_addr));
        chk("req_data_en", 64'(req_data_en), 64'(e_den));
        if (mo_owner >= 0 && mo_acked && !mo_zl)
            chk("m_wr_data", 64'(m_if.m_wr_data), 64'(req_data[mo_owner*DW +: DW]));

        for (int i = 0; i < N; i++) begin
            n_rdy[i]  += int'(req_ready[i]);
            n_done[i] += int'(req_done[i]);
            n_den[i]  += int'(req_data_en[i]);
            seen_rdy[i] = req_ready[i];
            seen_den[i] = req_data_en[i];
            if (req_ready[i] && req_done[i]) zl_both++;
            if (req_grant[i] && prev_grant == '0) order.push_back(i);
        end
        if (len_err) begin n_err_pulse++; err_cyc = cyc; end
        if (m_if.m_wr_done) mdone_cyc = cyc;
        if (m_if.m_wr_trig && first_trig < 0) first_trig = cyc;
        prev_grant = req_grant;

        p_rst = rst; p_init = init_end; p_trig = req_trig;
        p_den = m_if.m_wr_data_en; p_rdy = m_if.m_wr_ready; p_done = m_if.m_wr_done;
        for (int i = 0; i < N; i++) begin
            p_len[i] = int'(req_len[i*LW +: LW]);
            p_addr[i] = int'(req_addr[i*AW +: AW]);
        end
    endtask

    // One clock: drive inputs #1 after the edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        rst = rst_cmd;
        init_end = init_cmd;
        for (int i = 0; i < N; i++) begin
            if (seen_rdy[i] && pend[i] > 0) pend[i]--;
            if (seen_den[i]) beat[i]++;
            req_trig[i] = (pend[i] > 0);
            req_len[i*LW +: LW] = LW'(cl_len[i]);
            req_addr[i*AW +: AW] = AW'(cl_addr[i]);
            req_data[i*DW +: DW] = DW'((i << 12) | (beat[i] & 32'h0fff));
        end
        m_if.m_wr_data_en = 1'b0; m_if.m_wr_ready = 1'b0; m_if.m_wr_done = 1'b0;
        if (rst) begin
            ms = 0;
        end else begin
            case (ms)
                0: begin
                    if (stray_req) begin
                        m_if.m_wr_data_en = 1'b1; m_if.m_wr_ready = 1'b1; m_if.m_wr_done = 1'b1;
                        stray_req = 1'b0;
                    end else if (m_if.m_wr_trig) begin
                        wc = rdy_dly; ms = 1;
                    end
                end
                1: begin
                    wc--;
                    if (wc <= 0) begin
                        m_if.m_wr_ready = 1'b1;
                        bl = (beats_cfg < 0) ? int'(m_if.m_wr_len) : beats_cfg;
                        ms = 2;
                    end
                end
                default: begin
                    if (!gap_cfg || (cyc % 3) != 0) begin
                        m_if.m_wr_data_en = 1'b1;
                        bl--;
                        if (bl <= 0) begin m_if.m_wr_done = 1'b1; ms = 0; end
                    end
                end
            endcase
        end
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin n_rdy[i] = 0; n_done[i] = 0; n_den[i] = 0; end
        n_err_pulse = 0; err_cyc = -1; mdone_cyc = -1; first_trig = -1; zl_both = 0;
        order.delete();
    endtask

    task automatic do_reset();
        rst_cmd = 1'b1;
        for (int i = 0; i < N; i++) pend[i] = 0;
        repeat (3) tick();
        rst_cmd = 1'b0;
        clear_stats();
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < max_cyc) begin
            tick();
            n++;
            busy = (req_grant != '0) || (ms != 0) || m_if.m_wr_trig;
            for (int i = 0; i < N; i++) if (pend[i] > 0) busy = 1'b1;
        end
        chk({"timeout_", name}, 64'(busy), 64'(0));
    endtask

    initial begin
        rst = 1'b1; init_end = 1'b0; req_trig = '0; req_len = '0; req_addr = '0; req_data = '0;
        m_if.m_wr_data_en = 1'b0; m_if.m_wr_ready = 1'b0; m_if.m_wr_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; cl_len[i] = 0; cl_addr[i] = 0; beat[i] = 0;
            seen_rdy[i] = 1'b0; seen_den[i] = 1'b0; p_len[i] = 0; p_addr[i] = 0;
        end
        clear_stats();

        // Reset state
        do_reset();
        chk("rst_grant", 64'(req_grant), 64'(0));
        chk("rst_trig", 64'(m_if.m_wr_trig), 64'(0));
        chk("rst_addr", 64'(m_if.m_wr_addr), 64'(0));

        // S1: single client 0, len 64 at 0x100
        init_cmd = 1'b1; cl_len[0] = 64; cl_addr[0] = 32'h100; pend[0] = 1;
        wait_idle("s1", 400);
        chk("s1_ready0", 64'(n_rdy[0]), 64'(1));
        chk("s1_done0", 64'(n_done[0]), 64'(1));
        chk("s1_den0", 64'(n_den[0]), 64'(64));
        chk("s1_len_err", 64'(n_err_pulse), 64'(0));
        chk("s1_addr", 64'(m_if.m_wr_addr), 64'h100);
        chk("s1_ready1", 64'(n_rdy[1]), 64'(0));
        // Stray master strobes while idle are ignored
        stray_req = 1'b1;
        repeat (3) tick();
        chk("idle_stray_err", 64'(n_err_pulse), 64'(0));
        chk("idle_stray_den", 64'(n_den[0] + n_den[1]), 64'(64));

        // S2: both clients, four requests each, gapped data
        do_reset();
        gap_cfg = 1'b1;
        cl_len[0] = 4; cl_addr[0] = 32'h200; cl_len[1] = 6; cl_addr[1] = 32'h300;
        pend[0] = 4; pend[1] = 4;
        wait_idle("s2", 800);
        gap_cfg = 1'b0;
        chk("s2_order_len", 64'(order.size()), 64'(8));
        for (int k = 0; k < order.size() && k < 8; k++)
            chk("s2_order", 64'(order[k]), 64'(k % 2));
        chk("s2_done1", 64'(n_done[1]), 64'(4));

        // S3: no grant while init_end is low
        do_reset();
        init_cmd = 1'b0; cl_len[1] = 8; cl_addr[1] = 32'h40; pend[1] = 1;
        repeat (50) tick();
        chk("s3_no_trig", 64'(first_trig), 64'(-1));
        init_cmd = 1'b1;
        tick();
        begin
            int ic;
            ic = cyc;
            wait_idle("s3", 200);
            chk("s3_trig_cycle", 64'(first_trig), 64'(ic + 1));
        end

        // S4: zero-length request from client 1, then pointer favours client 0
        do_reset();
        cl_len[1] = 0; cl_addr[1] = 32'h500; pend[1] = 1;
        wait_idle("s4a", 50);
        chk("s4_ready_done_same", 64'(zl_both), 64'(1));
        chk("s4_no_trig", 64'(first_trig), 64'(-1));
        chk("s4_ready1", 64'(n_rdy[1]), 64'(1));
        cl_len[0] = 4; cl_len[1] = 5; pend[0] = 1; pend[1] = 1;
        wait_idle("s4b", 200);
        chk("s4_order_len", 64'(order.size()), 64'(3));
        if (order.size() >= 2) chk("s4_next_owner", 64'(order[1]), 64'(0));

        // S5: 63 beats for len 64, done with the 63rd beat
        do_reset();
        cl_len[0] = 64; cl_addr[0] = 32'h800; pend[0] = 1; beats_cfg = 63;
        wait_idle("s5", 400);
        beats_cfg = -1;
        chk("s5_err_count", 64'(n_err_pulse), 64'(1));
        chk("s5_err_cycle", 64'(err_cyc), 64'(mdone_cyc + 1));
        chk("s5_den0", 64'(n_den[0]), 64'(63));

        // S6: reset in the middle of the data phase
        do_reset();
        cl_len[0] = 64; cl_addr[0] = 32'h900; pend[0] = 1;
        begin
            int n;
            n = 0;
            while (n_den[0] < 10 && n < 200) begin tick(); n++; end
            chk("s6_ten_beats", 64'(n_den[0]), 64'(10));
        end
        rst_cmd = 1'b1;
        tick();
        rst_cmd = 1'b0;
        tick();
        chk("s6_grant", 64'(req_grant), 64'(0));
        chk("s6_trig", 64'(m_if.m_wr_trig), 64'(0));
        chk("s6_len", 64'(m_if.m_wr_len), 64'(0));
        chk("s6_addr", 64'(m_if.m_wr_addr), 64'(0));
        chk("s6_outs", 64'({req_ready, req_done, req_data_en, len_err}), 64'(0));
        clear_stats();
        cl_len[1] = 3; cl_addr[1] = 32'hA00; pend[1] = 1;
        wait_idle("s6", 200);
        chk("s6_fresh_done", 64'(n_done[1]), 64'(1));
        chk("s6_fresh_err", 64'(n_err_pulse), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
